parity_checker: RTL and testbench
=================================

# parity_checker

Receive-side partner of the team's 8-bit parity generator: accepts a data word plus its parity bit over a valid/ready stream, recomputes parity and forwards the word downstream tagged with a per-word error flag. It sits on the receive path of any link whose transmit side appends parity from the generator. The block keeps a sticky error flag and, optionally, a saturating error counter, both readable by control logic.

## Interface

- DATA_W, 8, data word width in bits (≥1)
- ODD, 0, parity sense: 0 = even (total ones in {data, parity} even), 1 = odd (total ones odd)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- s_valid  input  1  upstream word valid
- s_ready  output  1  block can accept a word this cycle
- s_data  input  DATA_W  received data word
- s_parity  input  1  received parity bit
- m_valid  output  1  checked word valid
- m_ready  input  1  downstream accepts word
- m_data  output  DATA_W  checked data word (unmodified)
- m_err  output  1  parity mismatch on the word in m_data
- clr_err  input  1  one-cycle clear of err_sticky and err_cnt
- err_sticky  output  1  set by any accepted word with a mismatch
- err_cnt  output  16  saturating count of mismatched words

## Operation

- Accept: s_valid & s_ready. Mismatch = (^{s_data, s_parity}) != ODD.
- Single output register stage. s_ready = ~m_valid | m_ready (combinational; full throughput when downstream is always ready).
- On accept: m_data <= s_data, m_err <= mismatch, m_valid <= 1.
- Output held stable while m_valid & ~m_ready; no accept in that cycle.
- m_valid & m_ready without accept: m_valid <= 0. With simultaneous accept: the new word replaces the old; m_valid stays 1.
- err_sticky: set on an accepted mismatch; cleared by clr_err. If clr_err and an accepted mismatch occur in the same cycle, the mismatch wins: err_sticky = 1.
- err_cnt: +1 per accepted mismatch, saturates at 0xFFFF. clr_err sets it to 0, or to 1 if an accepted mismatch occurs in the same cycle.
- Counting and flagging happen at accept time, not at downstream handshake.

## Timing

- Reset (rst_n = 0 at a clk edge): m_valid = 0, m_data = 0, m_err = 0, err_sticky = 0, err_cnt = 0. s_ready = 1 in the cycle after reset.
- Reset mid-operation discards any held word without a downstream handshake.
- Latency: a word accepted at edge N appears on m_* after edge N and is valid in cycle N+1.
- Throughput: 1 word per cycle when m_ready = 1.
- err_sticky and err_cnt update on the same edge as the accept.

## Configuration

- PARITY_CHK_ERR_CNT_EN defined: the 16-bit saturating err_cnt register is built as described above.
- Not defined: the counter is not built. The err_cnt port remains and is tied to 0. err_sticky, m_err and the handshake behave identically.

## Test plan

- ODD=0, m_ready=1: send 0x5A with parity 0 -> next cycle m_data=0x5A, m_err=0. Send 0x5A with parity 1 -> m_err=1, err_sticky=1, err_cnt=1.
- ODD=1: send 0x01 with parity 0 -> m_err=0. Send 0x00 with parity 0 -> m_err=1.
- Backpressure: hold m_ready=0 after 0x11 is accepted, keep s_valid=1 with 0x22 -> s_ready=0, m_data stays 0x11. Raise m_ready -> 0x11 is consumed and 0x22 is accepted in the same cycle; 0x22 appears next cycle; no word is lost or duplicated.
- Saturation (macro defined): force 65537 consecutive bad words -> err_cnt holds 0xFFFF. Pulse clr_err alone -> err_cnt=0, err_sticky=0. Pulse clr_err together with an accepted bad word -> err_cnt=1, err_sticky=1.
- Reset mid-stream: with m_valid=1 and m_ready=0, assert rst_n=0 for one edge -> m_valid=0, m_err=0, err_sticky=0, err_cnt=0; s_ready=1 the following cycle.
- Macro undefined: send 10 bad words -> err_cnt stays 0, err_sticky=1, and each word returns m_err=1.

Source files
------------

// File: rtl/parity_checker.sv
`timescale 1ns/1ps
// parity_checker
//
// Receive-side parity checker. It accepts a data word and its parity bit over
// a valid/ready stream and recomputes the parity. The word is then forwarded
// through a single output register stage, tagged with a per-word error flag.
// The block also keeps a sticky error flag and, optionally, a saturating
// mismatch counter for control logic.
//
// Build option:
//   PARITY_CHK_ERR_CNT_EN  defined   -> 16-bit saturating err_cnt is built
//                          undefined -> err_cnt port tied to 0
//
// Parameters:
//   DATA_W   data word width (>= 1)
//   ODD      0 = even parity over {data, parity}, 1 = odd parity
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   s_valid    upstream word valid
//   s_ready    block can accept a word this cycle
//   s_data     received data word
//   s_parity   received parity bit
//   m_valid    checked word valid
//   m_ready    downstream accepts word
//   m_data     checked data word (unmodified)
//   m_err      parity mismatch on the word in m_data
//   clr_err    one-cycle clear of err_sticky and err_cnt
//   err_sticky set by any accepted mismatching word
//   err_cnt    saturating count of mismatching words (0 when not built)

module parity_checker #(
    parameter int DATA_W = 8,
    parameter int ODD    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_parity,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_err,
    input  logic              clr_err,
    output logic              err_sticky,
    output logic [15:0]       err_cnt
);

    localparam logic ODD_SENSE = (ODD != 0);

    logic accept;
    logic mismatch;
    logic bad_word;

    // The register stage can take a new word when it is empty or being drained.
    assign s_ready  = ~m_valid | m_ready;
    assign accept   = s_valid & s_ready;
    assign mismatch = (^{s_data, s_parity}) != ODD_SENSE;
    assign bad_word = accept & mismatch;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_err   <= 1'b0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= s_data;
            m_err   <= mismatch;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // A mismatch arriving in the same cycle as a clear takes priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (bad_word) begin
            err_sticky <= 1'b1;
        end else if (clr_err) begin
            err_sticky <= 1'b0;
        end
    end

`ifdef PARITY_CHK_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (clr_err) begin
            err_cnt_q <= bad_word ? 16'd1 : 16'd0;
        end else if (bad_word && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_parity_checker.sv
`timescale 1ns/1ps
module tb_parity_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_parity;
    logic       m_ready;
    logic       clr_err;

    logic [1:0] sr, mv, me, es;
    logic [7:0] md [2];
    logic [15:0] ec [2];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    parity_checker #(.DATA_W(8), .ODD(0)) u_even (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(sr[0]),
        .s_data(s_data), .s_parity(s_parity), .m_valid(mv[0]), .m_ready(m_ready),
        .m_data(md[0]), .m_err(me[0]), .clr_err(clr_err), .err_sticky(es[0]),
        .err_cnt(ec[0])
    );

    parity_checker #(.DATA_W(8), .ODD(1)) u_odd (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(sr[1]),
        .s_data(s_data), .s_parity(s_parity), .m_valid(mv[1]), .m_ready(m_ready),
        .m_data(md[1]), .m_err(me[1]), .clr_err(clr_err), .err_sticky(es[1]),
        .err_cnt(ec[1])
    );

    // Behavioural model: one held word per instance plus error bookkeeping.
    bit         x_valid [2];
    logic [7:0] x_data  [2];
    bit         x_err   [2];
    bit         x_stk   [2];
    int         x_cnt   [2];

`ifdef PARITY_CHK_ERR_CNT_EN
    localparam bit CNT_BUILT = 1'b1;
`else
    localparam bit CNT_BUILT = 1'b0;
`endif

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit take, wrong;
            int ones;
            ones  = $countones(s_data) + int'(s_parity);
            wrong = (ones % 2) != i;
            take  = s_valid && (!x_valid[i] || m_ready);
            if (!rst_n) begin
                x_valid[i] <= 1'b0; x_data[i] <= 8'h00; x_err[i] <= 1'b0;
                x_stk[i]   <= 1'b0; x_cnt[i]  <= 0;
            end else begin
                if (take) begin
                    x_valid[i] <= 1'b1; x_data[i] <= s_data; x_err[i] <= wrong;
                end else if (m_ready) begin
                    x_valid[i] <= 1'b0;
                end
                if (take && wrong) x_stk[i] <= 1'b1;
                else if (clr_err)  x_stk[i] <= 1'b0;
                if (CNT_BUILT) begin
                    if (clr_err)            x_cnt[i] <= (take && wrong) ? 1 : 0;
                    else if (take && wrong) x_cnt[i] <= (x_cnt[i] >= 65535) ? 65535 : x_cnt[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", nm, inst, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("s_ready", i, 32'(sr[i]), 32'(!x_valid[i] || m_ready));
                chk("m_valid", i, 32'(mv[i]), 32'(x_valid[i]));
                if (x_valid[i]) begin
                    chk("m_data", i, 32'(md[i]), 32'(x_data[i]));
                    chk("m_err", i, 32'(me[i]), 32'(x_err[i]));
                end
                chk("err_sticky", i, 32'(es[i]), 32'(x_stk[i]));
                chk("err_cnt", i, 32'(ec[i]), 32'(x_cnt[i]));
            end
        end
    end

    task automatic step(input bit v, input logic [7:0] d, input bit p,
                        input bit mr, input bit c);
        s_valid = v; s_data = d; s_parity = p; m_ready = mr; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    // Parity bit that makes a word bad (bd=1) or good (bd=0) for the even instance.
    function automatic bit par_even(input logic [7:0] d, input bit bd);
        return (^d) ^ bd;
    endfunction

    initial begin
        rst_n = 1'b0; s_valid = 0; s_data = 0; s_parity = 0; m_ready = 1; clr_err = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_m_valid", 0, 32'(mv[0]), 0);
        chk("rst_s_ready", 0, 32'(sr[0]), 1);
        chk("rst_m_data", 0, 32'(md[0]), 0);
        chk("rst_err_cnt", 0, 32'(ec[0]), 0);

        // 0x5A has four ones.
        step(1, 8'h5A, 0, 1, 0);
        chk("5a_p0_data", 0, 32'(md[0]), 32'h5A);
        chk("5a_p0_err", 0, 32'(me[0]), 0);
        chk("5a_p0_err", 1, 32'(me[1]), 1);
        step(1, 8'h5A, 1, 1, 0);
        chk("5a_p1_err", 0, 32'(me[0]), 1);
        chk("5a_p1_stk", 0, 32'(es[0]), 1);
        chk("5a_p1_cnt", 0, 32'(ec[0]), CNT_BUILT ? 1 : 0);

        step(1, 8'h01, 0, 1, 0);
        chk("01_p0_err", 1, 32'(me[1]), 0);
        step(1, 8'h00, 0, 1, 0);
        chk("00_p0_err", 1, 32'(me[1]), 1);

        step(0, 8'h00, 0, 1, 1);
        chk("clr_stk", 0, 32'(es[0]), 0);
        chk("clr_cnt", 0, 32'(ec[0]), 0);

        // Backpressure.
        step(1, 8'h11, 0, 0, 0);
        chk("bp_first", 0, 32'(md[0]), 32'h11);
        s_data = 8'h22; #1;
        chk("bp_s_ready", 0, 32'(sr[0]), 0);
        step(1, 8'h22, 0, 0, 0);
        chk("bp_hold", 0, 32'(md[0]), 32'h11);
        step(1, 8'h22, 0, 0, 0);
        chk("bp_hold2", 0, 32'(md[0]), 32'h11);
        step(1, 8'h22, 0, 1, 0);
        chk("bp_next", 0, 32'(md[0]), 32'h22);
        chk("bp_next_v", 0, 32'(mv[0]), 1);
        step(0, 8'h00, 0, 1, 0);
        chk("bp_drain", 0, 32'(mv[0]), 0);

        // Reset while a bad word is held under backpressure.
        step(1, 8'h33, 1, 0, 0);
        chk("pre_rst_v", 0, 32'(mv[0]), 1);
        rst_n = 1'b0;
        step(1, 8'h44, 1, 0, 0);
        rst_n = 1'b1;
        chk("mid_rst_v", 0, 32'(mv[0]), 0);
        chk("mid_rst_err", 0, 32'(me[0]), 0);
        chk("mid_rst_stk", 0, 32'(es[0]), 0);
        chk("mid_rst_cnt", 0, 32'(ec[0]), 0);
        chk("mid_rst_rdy", 0, 32'(sr[0]), 1);

        for (int k = 0; k < 10; k++) begin
            logic [7:0] d;
            d = 8'(k * 37 + 3);
            step(1, d, par_even(d, 1), 1, 0);
            chk("bad10_err", 0, 32'(me[0]), 1);
        end
        chk("bad10_stk", 0, 32'(es[0]), 1);
        chk("bad10_cnt", 0, 32'(ec[0]), CNT_BUILT ? 10 : 0);

`ifdef PARITY_CHK_ERR_CNT_EN
        step(0, 8'h00, 0, 1, 1);
        for (int k = 0; k < 65537; k++) begin
            logic [7:0] d;
            d = 8'(k);
            step(1, d, par_even(d, 1), 1, 0);
        end
        chk("sat_cnt", 0, 32'(ec[0]), 32'hFFFF);
        step(0, 8'h00, 0, 1, 1);
        chk("sat_clr_cnt", 0, 32'(ec[0]), 0);
        chk("sat_clr_stk", 0, 32'(es[0]), 0);
`endif
        step(1, 8'hA5, par_even(8'hA5, 1), 1, 1);
        chk("clr_bad_cnt", 0, 32'(ec[0]), CNT_BUILT ? 1 : 0);
        chk("clr_bad_stk", 0, 32'(es[0]), 1);

        step(0, 8'h00, 0, 1, 0);
        step(0, 8'h00, 0, 1, 0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
